// File: rtl/data_pack_if.sv
// Stream bundle for data_pack: IN_W-bit value stream in, OUT_W-bit word stream out.
// err_out exists only when DATA_PACK_ERR_EN is defined.
interface data_pack_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 32
);
  logic             valid_in;
  logic             ready_out;
  logic [IN_W-1:0]  data_in;
  logic             sop_in;
  logic             eop_in;
  logic             valid_out;
  logic             ready_in;
  logic [OUT_W-1:0] data_out;
  logic             sop_out;
  logic             eop_out;
`ifdef DATA_PACK_ERR_EN
  logic             err_out;

  modport slave (
    input  valid_in, data_in, sop_in, eop_in, ready_in,
    output ready_out, valid_out, data_out, sop_out, eop_out, err_out
  );
  modport master (
    output valid_in, data_in, sop_in, eop_in, ready_in,
    input  ready_out, valid_out, data_out, sop_out, eop_out, err_out
  );
`else
  modport slave (
    input  valid_in, data_in, sop_in, eop_in, ready_in,
    output ready_out, valid_out, data_out, sop_out, eop_out
  );
  modport master (
    output valid_in, data_in, sop_in, eop_in, ready_in,
    input  ready_out, valid_out, data_out, sop_out, eop_out
  );
`endif
endinterface

// File: rtl/data_pack.sv
// Transmit-side packer: IN_W-bit values LSB-first into OUT_W-bit words with sop/eop framing.
// Optional DATA_PACK_ERR_EN adds err_out and restarts a packet on an unexpected sop_in.
module data_pack #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  data_pack_if.slave bus
);
  localparam int AW = OUT_W + IN_W - 1;
  localparam int CW = $clog2(OUT_W);
  localparam int SW = $clog2(OUT_W + IN_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PACK  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d, ins;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             run_q;
  logic             valid_q, sop_q, eop_q;
  logic [OUT_W-1:0] data_q;

  logic [SW-1:0]    cnt_x, sum;
  logic             word_full, restart, would_emit, out_free, ready, accept;
  logic             emit, emit_sop, emit_eop;
  logic [OUT_W-1:0] emit_data;

  assign cnt_x     = SW'(cnt_q);
  assign sum       = cnt_x + SW'(IN_W);
  assign word_full = (sum >= SW'(OUT_W));

`ifdef DATA_PACK_ERR_EN
  assign restart = (state_q == PACK) & bus.sop_in;
`else
  assign restart = 1'b0;
`endif

  // In IDLE (or on a restart) only a sop+eop value produces a word; in PACK it depends on the fill level.
  assign would_emit = ((state_q == PACK) & word_full)
                    | (bus.sop_in & bus.eop_in & ((state_q == IDLE) | restart));
  assign out_free   = !valid_q | bus.ready_in;
  assign ready      = run_q & (state_q != FLUSH) & !(!out_free & would_emit);
  assign accept     = bus.valid_in & ready;

  always_comb begin
    ins = acc_q;
    ins[cnt_x +: IN_W] = bus.data_in;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    emit      = 1'b0;
    emit_data = '0;
    emit_sop  = 1'b0;
    emit_eop  = 1'b0;
    if (state_q == FLUSH) begin
      if (out_free) begin
        emit      = 1'b1;
        emit_data = acc_q[OUT_W-1:0];
        emit_sop  = first_q;
        emit_eop  = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        first_d   = 1'b0;
        state_d   = IDLE;
      end
    end else if (accept) begin
      if ((state_q == IDLE) || restart) begin
        if (bus.sop_in && bus.eop_in) begin
          emit      = 1'b1;
          emit_data = OUT_W'(bus.data_in);
          emit_sop  = 1'b1;
          emit_eop  = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          first_d   = 1'b0;
          state_d   = IDLE;
        end else if (bus.sop_in) begin
          acc_d   = AW'(bus.data_in);
          cnt_d   = CW'(IN_W);
          first_d = 1'b1;
          state_d = PACK;
        end
      end else begin
        if (word_full) begin
          emit      = 1'b1;
          emit_data = ins[OUT_W-1:0];
          emit_sop  = first_q;
          first_d   = 1'b0;
          acc_d     = ins >> OUT_W;
          cnt_d     = CW'(sum - SW'(OUT_W));
        end else begin
          acc_d = ins;
          cnt_d = CW'(sum);
        end
        if (bus.eop_in) begin
          if (sum == SW'(OUT_W)) begin
            emit_eop = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the accumulator, is reset so an aborted packet leaves no residue.
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      run_q   <= 1'b1;
    end
  end

  // Single-entry output register; holds its word while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (emit) begin
      valid_q <= 1'b1;
      data_q  <= emit_data;
      sop_q   <= emit_sop;
      eop_q   <= emit_eop;
    end else if (bus.ready_in) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DATA_PACK_ERR_EN
  logic err_q, err_d;

  assign err_d = accept & (restart | ((state_q == IDLE) & bus.eop_in & !bus.sop_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err_out = err_q;
`endif

  assign bus.ready_out = ready;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.sop_out   = sop_q;
  assign bus.eop_out   = eop_q;
endmodule
